// File: rtl/alu_sequencer.sv
// Initiator for the 8-bit combinational ALU: request/response handshakes, op decode, carry keeping.
// Optional shift-and-add multiply on opcode 7 is enabled by defining ALU_SEQ_MUL_EN.
module alu_sequencer #(
   parameter int WIDTH = 8,
   parameter int OPC_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OPC_W-1:0] req_opcode,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_carry_en,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [WIDTH-1:0] rsp_result_hi,
   output logic [WIDTH-1:0] rsp_flags,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [WIDTH-1:0] alu_fi,
   output logic [6:0]       alu_op,
   input  logic [WIDTH-1:0] alu_d,
   input  logic [WIDTH-1:0] alu_fo
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, RESP = 2'd3} state_t;

   function automatic logic [6:0] op_onehot(input logic [OPC_W-1:0] opc);
      logic [6:0] oh;
      case (opc)
         4'd0:    oh = 7'b0000001;
         4'd1:    oh = 7'b0000010;
         4'd2:    oh = 7'b0000100;
         4'd3:    oh = 7'b0001000;
         4'd4:    oh = 7'b0010000;
         4'd5:    oh = 7'b0100000;
         4'd6:    oh = 7'b1000000;
         default: oh = 7'b0000000;
      endcase
      return oh;
   endfunction

   state_t           state_r, state_s;
   logic             carry_r, carry_s;
   logic             arith_r, arith_s;
   logic [WIDTH-1:0] res_r, res_s, hi_r, hi_s, flags_r, flags_s;
   logic [WIDTH-1:0] alu_a_r, alu_a_s, alu_b_r, alu_b_s, alu_fi_r, alu_fi_s;
   logic [6:0]       alu_op_r, alu_op_s;
   logic             req_ready_r, rsp_valid_r;
   logic             unused_s;
`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0] mcand_r, mcand_s, acc_hi_r, acc_hi_s, acc_lo_r, acc_lo_s;
   logic [2:0]       cnt_r, cnt_s;
   logic             mul_zero_s;
`endif

   assign unused_s = &{1'b0, alu_fo[WIDTH-1:3]};

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_s  = state_r;
      carry_s  = carry_r;
      arith_s  = arith_r;
      res_s    = res_r;
      hi_s     = hi_r;
      flags_s  = flags_r;
      alu_op_s = 7'b0000000;
      alu_a_s  = '0;
      alu_b_s  = '0;
      alu_fi_s = '0;
`ifdef ALU_SEQ_MUL_EN
      mcand_s    = mcand_r;
      acc_hi_s   = acc_hi_r;
      acc_lo_s   = acc_lo_r;
      cnt_s      = cnt_r;
      mul_zero_s = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (req_opcode < 4'd7) begin
                  state_s  = EXEC;
                  arith_s  = (req_opcode < 4'd2);
                  alu_op_s = op_onehot(req_opcode);
                  alu_a_s  = req_a;
                  alu_b_s  = req_b;
                  alu_fi_s = {{(WIDTH-1){1'b0}}, req_carry_en & carry_r};
               end
`ifdef ALU_SEQ_MUL_EN
               else if (req_opcode == 4'd7) begin
                  // Multiplier sits in acc_lo and is shifted out LSB first
                  state_s  = MUL;
                  mcand_s  = req_a;
                  acc_hi_s = '0;
                  acc_lo_s = req_b;
                  cnt_s    = 3'd0;
                  alu_op_s = 7'b0000001;
                  alu_b_s  = req_b[0] ? req_a : '0;
               end
`endif
               else begin
                  state_s = RESP;
                  res_s   = '0;
                  hi_s    = '0;
                  flags_s = {1'b1, {(WIDTH-1){1'b0}}};
               end
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            state_s = RESP;
            res_s   = alu_d;
            hi_s    = '0;
            if (arith_r) begin
               carry_s = alu_fo[0];
               flags_s = {{(WIDTH-3){1'b0}}, alu_fo[2:1], alu_fo[0]};
            end else begin
               flags_s = {{(WIDTH-3){1'b0}}, alu_fo[2:1], carry_r};
            end
         end
         MUL: begin
`ifdef ALU_SEQ_MUL_EN
            acc_hi_s = {alu_fo[0], alu_d[WIDTH-1:1]};
            acc_lo_s = {alu_d[0], acc_lo_r[WIDTH-1:1]};
            cnt_s    = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
               mul_zero_s = ({acc_hi_s, acc_lo_s} == '0);
               state_s    = RESP;
               res_s      = acc_lo_s;
               hi_s       = acc_hi_s;
               flags_s    = {{(WIDTH-3){1'b0}}, ~mul_zero_s, mul_zero_s, 1'b0};
            end else begin
               state_s  = MUL;
               alu_op_s = 7'b0000001;
               alu_a_s  = acc_hi_s;
               alu_b_s  = acc_lo_s[0] ? mcand_r : '0;
            end
`else
            state_s = IDLE;
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State, datapath and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         carry_r     <= 1'b0;
         arith_r     <= 1'b0;
         res_r       <= '0;
         hi_r        <= '0;
         flags_r     <= '0;
         alu_op_r    <= 7'b0000000;
         alu_a_r     <= '0;
         alu_b_r     <= '0;
         alu_fi_r    <= '0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         mcand_r  <= '0;
         acc_hi_r <= '0;
         acc_lo_r <= '0;
         cnt_r    <= 3'd0;
`endif
      end else begin
         state_r     <= state_s;
         carry_r     <= carry_s;
         arith_r     <= arith_s;
         res_r       <= res_s;
         hi_r        <= hi_s;
         flags_r     <= flags_s;
         alu_op_r    <= alu_op_s;
         alu_a_r     <= alu_a_s;
         alu_b_r     <= alu_b_s;
         alu_fi_r    <= alu_fi_s;
         req_ready_r <= (state_s == IDLE);
         rsp_valid_r <= (state_s == RESP);
`ifdef ALU_SEQ_MUL_EN
         mcand_r  <= mcand_s;
         acc_hi_r <= acc_hi_s;
         acc_lo_r <= acc_lo_s;
         cnt_r    <= cnt_s;
`endif
      end
   end

   assign req_ready     = req_ready_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_result    = res_r;
   assign rsp_result_hi = hi_r;
   assign rsp_flags     = flags_r;
   assign alu_op        = alu_op_r;
   assign alu_a         = alu_a_r;
   assign alu_b         = alu_b_r;
   assign alu_fi        = alu_fi_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU model, vector table, scoreboard queue, reset-abort sequence.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0, req_ready, req_carry_en = 1'b0;
   logic [3:0] req_opcode = 4'd0;
   logic [7:0] req_a = 8'h00, req_b = 8'h00;
   logic       rsp_valid, rsp_ready = 1'b0;
   logic [7:0] rsp_result, rsp_result_hi, rsp_flags;
   logic [7:0] alu_a, alu_b, alu_fi, alu_d, alu_fo;
   logic [6:0] alu_op;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] opc;
      logic [7:0] a, b;
      logic       cen;
      logic [7:0] res, hi, flg;
      int         lat;
      int         hold;
   } vec_t;

   typedef struct {
      logic [7:0] res, hi, flg;
      int         lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   alu_sequencer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b), .req_carry_en(req_carry_en),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_result_hi(rsp_result_hi), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fi(alu_fi), .alu_op(alu_op),
      .alu_d(alu_d), .alu_fo(alu_fo)
   );

   always #5 clk = ~clk;

   // Reference combinational ALU: SUB carry is a borrow, shifts by b[2:0]
   always_comb begin
      logic [8:0] t;
      t = 9'd0;
      case (alu_op)
         7'b0000001: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_fi[0]};
         7'b0000010: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_fi[0]};
         7'b0000100: t = {1'b0, alu_a & alu_b};
         7'b0001000: t = {1'b0, alu_a | alu_b};
         7'b0010000: t = {1'b0, ~alu_a};
         7'b0100000: t = {1'b0, alu_a << alu_b[2:0]};
         7'b1000000: t = {1'b0, alu_a >> alu_b[2:0]};
         default:    t = 9'd0;
      endcase
      alu_d  = t[7:0];
      alu_fo = {5'd0, ($signed(t[7:0]) > 8'sd0), (t[7:0] == 8'h00), t[8]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v);
      exp_t e;
      int   lat;
      bit   got;
      logic [6:0] exp_op;
      @(negedge clk);
      chk("ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_opcode = v.opc; req_a = v.a; req_b = v.b; req_carry_en = v.cen;
      @(posedge clk); #1;
      req_valid = 1'b0;
      sb.push_back('{v.res, v.hi, v.flg, v.lat});
      if (v.opc < 4'd7) begin
         exp_op = 7'b0000001 << v.opc;
         chk("exec_alu_op", {25'd0, alu_op}, {25'd0, exp_op});
      end
      lat = 1;
      got = 1'b0;
      while (!got && lat <= 20) begin
         if (rsp_valid) got = 1'b1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      e = sb.pop_front();
      if (!got) begin
         chk("rsp_timeout", 32'd0, 32'd1);
         return;
      end
      chk("latency", lat, e.lat);
      chk("result", {24'd0, rsp_result}, {24'd0, e.res});
      chk("result_hi", {24'd0, rsp_result_hi}, {24'd0, e.hi});
      chk("flags", {24'd0, rsp_flags}, {24'd0, e.flg});
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_result", {24'd0, rsp_result}, {24'd0, e.res});
         chk("hold_flags", {24'd0, rsp_flags}, {24'd0, e.flg});
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
         chk("hold_alu_op", {25'd0, alu_op}, 32'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_opcode = 4'hA;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("handoff_valid_drop", {31'd0, rsp_valid}, 32'd0);
      chk("handoff_no_accept", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      vecs.push_back('{4'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 8'h05, 2, 0});
      vecs.push_back('{4'd0, 8'h01, 8'h01, 1'b1, 8'h03, 8'h00, 8'h04, 2, 0});
      vecs.push_back('{4'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 8'h01, 2, 0});
      vecs.push_back('{4'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 8'h05, 2, 0});
      vecs.push_back('{4'd1, 8'h05, 8'h05, 1'b0, 8'h00, 8'h00, 8'h02, 2, 0});
      vecs.push_back('{4'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 8'h04, 2, 0});
      vecs.push_back('{4'd5, 8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 8'h04, 2, 0});
      vecs.push_back('{4'd6, 8'h80, 8'h07, 1'b0, 8'h01, 8'h00, 8'h04, 2, 0});
      vecs.push_back('{4'd4, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 8'h00, 2, 0});
      vecs.push_back('{4'hA, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 8'h80, 1, 5});
      vecs.push_back('{4'hF, 8'h55, 8'hAA, 1'b1, 8'h00, 8'h00, 8'h80, 1, 0});
      vecs.push_back('{4'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 8'h05, 2, 0});
`ifdef ALU_SEQ_MUL_EN
      vecs.push_back('{4'd7, 8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 8'h04, 9, 0});
      vecs.push_back('{4'd7, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 8'h04, 9, 2});
      vecs.push_back('{4'd7, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 8'h02, 9, 0});
`else
      vecs.push_back('{4'd7, 8'h0F, 8'h11, 1'b0, 8'h00, 8'h00, 8'h80, 1, 0});
`endif
      vecs.push_back('{4'd0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h00, 8'h04, 2, 0});

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_result", {8'd0, rsp_result, rsp_result_hi, rsp_flags}, 32'd0);
      chk("rst_alu", {alu_op[6:0], 1'b0, alu_a, alu_b, alu_fi}, 32'd0);

      for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

      // Abort a long operation with reset after loading carry=1
      do_req('{4'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 8'h05, 2, 0});
      @(negedge clk);
      req_valid = 1'b1; req_opcode = 4'd7; req_a = 8'h0F; req_b = 8'h11; req_carry_en = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
`ifdef ALU_SEQ_MUL_EN
      chk("mul_alu_op", {25'd0, alu_op}, 32'd1);
`else
      chk("illegal7_pending", {31'd0, rsp_valid}, 32'd1);
`endif
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_alu_op", {25'd0, alu_op}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_req('{4'd0, 8'h01, 8'h01, 1'b1, 8'h02, 8'h00, 8'h04, 2, 0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
